// File: rtl/uart_receiver.sv
// UART receive engine: two-flop synchroniser on rx_pin, start-bit
// validation at mid-bit, BIT_WIDTH data samples, optional parity and a stop
// check. One word is held behind a rx_valid/read handshake, with a sticky
// overrun flag when a finished frame finds the holding register still full.
// Assumes BIT_WIDTH >= 2 and CLKS_PER_BIT >= 2.
module uart_receiver #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned BIT_WIDTH  = 8,
    parameter logic        START_BIT  = 1'b0,
    parameter bit          LSB_TO_MSB = 1'b1,
    parameter int unsigned PARITY_SEL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    input  logic                 read,
    output logic [BIT_WIDTH-1:0] rx_reg,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = $clog2(BIT_WIDTH + 1);

    localparam logic             IDLE_LVL = ~START_BIT;
    localparam logic             PAR_ODD  = (PARITY_SEL == 2);
    localparam logic             HAS_PAR  = (PARITY_SEL != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [BIT_WIDTH-1:0] shift;
    logic [BIT_WIDTH-1:0] shift_in;
    logic                 par_acc;
    logic                 par_bad;
    logic                 rx_meta;
    logic                 rx_s;

    // Two-flop synchroniser, preset to the idle line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= IDLE_LVL;
            rx_s    <= IDLE_LVL;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
        end
    end

    // Next shift-register value: after BIT_WIDTH shifts the first bit sits
    // at bit 0 (LSB first) or at the top bit (MSB first).
    always_comb begin
        shift_in = shift;
        if (LSB_TO_MSB)
            shift_in = {rx_s, shift[BIT_WIDTH-1:1]};
        else
            shift_in = {shift[BIT_WIDTH-2:0], rx_s};
    end

    // Receive FSM, handshake and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            rx_reg     <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Consuming a word clears overrun with it; a completion later in
            // this block may re-assert rx_valid in the same cycle.
            if (rx_valid && read) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_s == START_BIT) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s == START_BIT) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            par_acc <= 1'b0;
                            par_bad <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= shift_in;
                        par_acc <= par_acc ^ rx_s;
                        if (bit_idx == IDX_LAST)
                            state <= HAS_PAR ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bad <= ((par_acc ^ rx_s) != PAR_ODD);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!rx_valid || read) begin
                            rx_reg     <= shift;
                            parity_err <= par_bad;
                            frame_err  <= (rx_s != IDLE_LVL);
                            rx_valid   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        if (rx_s == IDLE_LVL) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s == IDLE_LVL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: two instances (no parity / even parity) at
// 10 clocks per bit. Table-driven frame vectors plus directed sequences for
// latency, glitch rejection, break handling, overrun and mid-frame reset.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       read_a = 1'b0, read_b = 1'b0;
    logic [7:0] rx_reg_a, rx_reg_b;
    logic       rx_valid_a, busy_a, parity_err_a, frame_err_a, overrun_a;
    logic       rx_valid_b, busy_b, parity_err_b, frame_err_b, overrun_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_a   = -1;
    logic prev_va = 1'b0;

    uart_receiver #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .BIT_WIDTH(8),
        .START_BIT(1'b0), .LSB_TO_MSB(1'b1), .PARITY_SEL(0)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_pin(rx_a), .read(read_a),
        .rx_reg(rx_reg_a), .rx_valid(rx_valid_a), .busy(busy_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a)
    );

    uart_receiver #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .BIT_WIDTH(8),
        .START_BIT(1'b0), .LSB_TO_MSB(1'b1), .PARITY_SEL(1)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_pin(rx_b), .read(read_b),
        .rx_reg(rx_reg_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the cycle number at which rx_valid on instance A first rises.
    always @(negedge clk) begin
        if (rx_valid_a && !prev_va && rise_a < 0) rise_a = cyc;
        prev_va = rx_valid_a;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         sel_b;
        logic [7:0] data;
        bit         par_bit;
        bit         stop_lvl;
        logic [7:0] exp_reg;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else       rx_a = v;
    endtask

    task automatic send(input bit sel_b, input logic [7:0] data, input bit has_par,
                        input bit par_bit, input bit stop_lvl, input int stop_len);
        set_line(sel_b, 1'b0);
        tick(10);
        for (int i = 0; i < 8; i++) begin
            set_line(sel_b, data[i]);
            tick(10);
        end
        if (has_par) begin
            set_line(sel_b, par_bit);
            tick(10);
        end
        set_line(sel_b, stop_lvl);
        tick(stop_len);
        set_line(sel_b, 1'b1);
    endtask

    task automatic pulse_read(input bit sel_b);
        if (sel_b) read_b = 1'b1;
        else       read_a = 1'b1;
        tick(1);
        read_a = 1'b0;
        read_b = 1'b0;
    endtask

    initial begin
        int t0;
        bit seen_busy;

        vecs[0] = '{0, 8'hA5, 0, 1, 8'hA5, 0, 0};
        vecs[1] = '{0, 8'h00, 0, 1, 8'h00, 0, 0};
        vecs[2] = '{0, 8'h5A, 0, 0, 8'h5A, 0, 1};
        vecs[3] = '{0, 8'hFF, 0, 1, 8'hFF, 0, 0};
        vecs[4] = '{0, 8'h81, 0, 1, 8'h81, 0, 0};
        vecs[5] = '{1, 8'h03, 1, 1, 8'h03, 1, 0};
        vecs[6] = '{1, 8'h03, 0, 1, 8'h03, 0, 0};
        vecs[7] = '{1, 8'hFF, 0, 1, 8'hFF, 0, 0};
        vecs[8] = '{1, 8'h80, 1, 1, 8'h80, 0, 0};
        vecs[9] = '{1, 8'h80, 0, 1, 8'h80, 1, 0};

        // Reset state
        tick(3);
        check("reset rx_reg", rx_reg_a, 8'h00);
        check("reset rx_valid", rx_valid_a, 0);
        check("reset busy", busy_a, 0);
        check("reset errs", {parity_err_a, frame_err_a, overrun_a}, 0);
        rst = 1'b1;
        tick(5);

        // Latency from the start edge to rx_valid
        t0 = cyc;
        send(0, 8'hA5, 0, 0, 1, 10);
        tick(3);
        check("latency", rise_a - t0, 98);
        check("lat rx_reg", rx_reg_a, 8'hA5);
        check("lat flags", {parity_err_a, frame_err_a, overrun_a}, 0);
        pulse_read(0);
        check("lat read clears", rx_valid_a, 0);
        tick(5);

        // Frame vectors
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].sel_b, vecs[i].data, vecs[i].sel_b, vecs[i].par_bit,
                 vecs[i].stop_lvl, 10);
            tick(5);
            if (vecs[i].sel_b) begin
                check($sformatf("v%0d valid", i), rx_valid_b, 1);
                check($sformatf("v%0d rx_reg", i), rx_reg_b, vecs[i].exp_reg);
                check($sformatf("v%0d parity_err", i), parity_err_b, vecs[i].exp_perr);
                check($sformatf("v%0d frame_err", i), frame_err_b, vecs[i].exp_ferr);
                check($sformatf("v%0d busy", i), busy_b, 0);
            end else begin
                check($sformatf("v%0d valid", i), rx_valid_a, 1);
                check($sformatf("v%0d rx_reg", i), rx_reg_a, vecs[i].exp_reg);
                check($sformatf("v%0d parity_err", i), parity_err_a, vecs[i].exp_perr);
                check($sformatf("v%0d frame_err", i), frame_err_a, vecs[i].exp_ferr);
                check($sformatf("v%0d busy", i), busy_a, 0);
            end
            pulse_read(vecs[i].sel_b);
            check($sformatf("v%0d read clears", i),
                  vecs[i].sel_b ? rx_valid_b : rx_valid_a, 0);
            tick(3);
        end

        // Start glitch of 3 cycles is rejected
        seen_busy = 1'b0;
        rx_a = 1'b0;
        tick(3);
        rx_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) seen_busy = 1'b1;
            tick(1);
        end
        check("glitch busy seen", seen_busy, 1);
        check("glitch busy end", busy_a, 0);
        check("glitch valid", rx_valid_a, 0);
        check("glitch flags", {parity_err_a, frame_err_a, overrun_a}, 0);
        tick(5);

        // Stop bit held low for 30 cycles (break)
        send(0, 8'h55, 0, 0, 0, 30);
        check("break busy held", busy_a, 1);
        check("break valid", rx_valid_a, 1);
        check("break rx_reg", rx_reg_a, 8'h55);
        check("break frame_err", frame_err_a, 1);
        tick(5);
        check("break busy released", busy_a, 0);
        tick(50);
        check("break no second word", overrun_a, 0);
        check("break word kept", rx_reg_a, 8'h55);
        pulse_read(0);
        check("break read clears", rx_valid_a, 0);
        tick(5);

        // Back-to-back frames without reading -> overrun
        send(0, 8'h11, 0, 0, 1, 10);
        send(0, 8'h22, 0, 0, 1, 10);
        tick(5);
        check("ovr rx_reg", rx_reg_a, 8'h11);
        check("ovr valid", rx_valid_a, 1);
        check("ovr set", overrun_a, 1);
        pulse_read(0);
        check("ovr read valid", rx_valid_a, 0);
        check("ovr read clears", overrun_a, 0);
        tick(5);

        // Reset mid-frame with a pending word and overrun
        send(0, 8'h99, 0, 0, 1, 10);
        send(0, 8'h77, 0, 0, 1, 10);
        tick(5);
        check("pre-reset overrun", overrun_a, 1);
        fork
            send(0, 8'hFF, 0, 0, 1, 10);
            begin
                tick(40);
                rst = 1'b0;
                tick(1);
                check("mid rst valid", rx_valid_a, 0);
                check("mid rst rx_reg", rx_reg_a, 8'h00);
                check("mid rst busy", busy_a, 0);
                check("mid rst flags", {parity_err_a, frame_err_a, overrun_a}, 0);
                rst = 1'b1;
            end
        join
        tick(5);
        check("post rst idle", busy_a, 0);
        send(0, 8'h3C, 0, 0, 1, 10);
        tick(5);
        check("post rst valid", rx_valid_a, 1);
        check("post rst rx_reg", rx_reg_a, 8'h3C);
        check("post rst flags", {parity_err_a, frame_err_a, overrun_a}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
